polar_fg_sched: RTL and testbench

POLAR_FG_SCHED -- requirements
Module: polar_fg_sched

---
 rtl/polar_pkg.sv | 30 +++
 rtl/polar_pe.sv | 55 +++++
 rtl/polar_fg_sched.sv | 117 +++++++++++
 tb/tb_polar_fg_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
// polar_pkg: shared types and constants for the polar F/G node scheduler.
//   polar_op_t      - node operation: PL_OP_F (min-sum) or PL_OP_G (add/sub)
//   sched_state_t   - scheduler FSM state, exported on the debug port
//   POLAR_LLR_W     - default signed LLR width
//   LLR_MAX/LLR_MIN - symmetric saturation limits at the default width
//   llr_max()       - positive saturation limit for any LLR width
package polar_pkg;

  typedef enum logic {
    PL_OP_F = 1'b0,
    PL_OP_G = 1'b1
  } polar_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  localparam int POLAR_LLR_W = 8;

  // Symmetric range: -2^(W-1) is never produced, so |x| always fits in W bits.
  localparam logic signed [POLAR_LLR_W-1:0] LLR_MAX = 8'sh7F;
  localparam logic signed [POLAR_LLR_W-1:0] LLR_MIN = 8'sh81;

  function automatic int llr_max(input int w);
    return (2 ** (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/polar_pe.sv
// polar_pe: combinational polar processing element.
//   a_i, b_i : signed LLR operands (never equal to -2^(LLR_W-1))
//   u_i      : partial-sum bit, selects b+a (0) or b-a (1) for G
//   op_i     : PL_OP_F or PL_OP_G
//   res_o    : signed result, saturated to +/-(2^(LLR_W-1)-1)
module polar_pe
  import polar_pkg::*;
#(
  parameter int LLR_W = POLAR_LLR_W
) (
  input  logic signed [LLR_W-1:0] a_i,
  input  logic signed [LLR_W-1:0] b_i,
  input  logic                    u_i,
  input  polar_op_t               op_i,
  output logic signed [LLR_W-1:0] res_o
);

  localparam int SAT = llr_max(LLR_W);

  logic signed [LLR_W:0]   w_max_x;
  logic signed [LLR_W:0]   w_min_x;
  logic signed [LLR_W:0]   w_sum;
  logic        [LLR_W-1:0] w_abs_a;
  logic        [LLR_W-1:0] w_abs_b;
  logic        [LLR_W-1:0] w_min_mag;
  logic                    w_sign;
  logic signed [LLR_W-1:0] w_f_res;
  logic signed [LLR_W-1:0] w_g_res;

  assign w_max_x = (LLR_W+1)'(SAT);
  assign w_min_x = -w_max_x;

  // F: sign(a)^sign(b) applied to min(|a|,|b|); a tie keeps |a|.
  assign w_abs_a   = a_i[LLR_W-1] ? -a_i : a_i;
  assign w_abs_b   = b_i[LLR_W-1] ? -b_i : b_i;
  assign w_min_mag = (w_abs_a <= w_abs_b) ? w_abs_a : w_abs_b;
  assign w_sign    = a_i[LLR_W-1] ^ b_i[LLR_W-1];
  assign w_f_res   = w_sign ? -w_min_mag : w_min_mag;

  // G: one extra bit of headroom, then clamp to the symmetric range.
  assign w_sum = u_i ? ({b_i[LLR_W-1], b_i} - {a_i[LLR_W-1], a_i})
                     : ({b_i[LLR_W-1], b_i} + {a_i[LLR_W-1], a_i});

  always_comb begin
    w_g_res = w_sum[LLR_W-1:0];
    if (w_sum > w_max_x) begin
      w_g_res = w_max_x[LLR_W-1:0];
    end else if (w_sum < w_min_x) begin
      w_g_res = w_min_x[LLR_W-1:0];
    end
  end

  assign res_o = (op_i == PL_OP_G) ? w_g_res : w_f_res;

endmodule

// File: rtl/polar_fg_sched.sv
// polar_fg_sched: serial F/G node scheduler around one time-multiplexed PE.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_valid_i/req_ready_o : request handshake (op, LLR vector, u bits)
//   req_op_i, req_llr_i     : node operation and N_LLR-element LLR vector
//   req_u_i                 : partial sums for G, one per output slot
//   res_valid_o/res_ready_i : result handshake
//   res_llr_o               : N_LLR/2-element result vector
//   busy_o                  : FSM not IDLE
//   dbg_state_o             : current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; the sender holds its data stable until then, and ready
// never depends combinationally on valid.
module polar_fg_sched
  import polar_pkg::*;
#(
  parameter int N_LLR = 8,
  parameter int LLR_W = POLAR_LLR_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  polar_op_t                     req_op_i,
  input  logic [N_LLR*LLR_W-1:0]        req_llr_i,
  input  logic [N_LLR/2-1:0]            req_u_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [(N_LLR/2)*LLR_W-1:0]    res_llr_o,
  output logic                          busy_o,
  output sched_state_t                  dbg_state_o
);

  localparam int HALF = N_LLR / 2;
  localparam int CW   = $clog2(HALF);
  localparam logic [LLR_W-1:0] NEG_MIN   = {1'b1, {(LLR_W-1){1'b0}}};
  localparam logic [LLR_W-1:0] NEG_CLAMP = {1'b1, {(LLR_W-2){1'b0}}, 1'b1};

  sched_state_t                r_state;
  polar_op_t                   r_op;
  logic [N_LLR*LLR_W-1:0]      r_llr;
  logic [HALF-1:0]             r_u;
  logic [CW-1:0]               r_k;
  logic [HALF*LLR_W-1:0]       r_res;
  logic                        r_res_valid;

  logic [N_LLR*LLR_W-1:0]      w_llr_in;
  logic signed [LLR_W-1:0]     w_pe_a;
  logic signed [LLR_W-1:0]     w_pe_b;
  logic signed [LLR_W-1:0]     w_pe_res;

  // Clamp -2^(W-1) on the way in so the PE never has to negate it.
  for (genvar i = 0; i < N_LLR; i++) begin : g_clamp
    assign w_llr_in[i*LLR_W +: LLR_W] =
      (req_llr_i[i*LLR_W +: LLR_W] == NEG_MIN) ? NEG_CLAMP
                                                : req_llr_i[i*LLR_W +: LLR_W];
  end

  assign w_pe_a = r_llr[int'(r_k)*LLR_W +: LLR_W];
  assign w_pe_b = r_llr[(int'(r_k)+HALF)*LLR_W +: LLR_W];

  polar_pe #(.LLR_W(LLR_W)) u_pe (
    .a_i   (w_pe_a),
    .b_i   (w_pe_b),
    .u_i   (r_u[r_k]),
    .op_i  (r_op),
    .res_o (w_pe_res)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_op        <= PL_OP_F;
      r_llr       <= '0;
      r_u         <= '0;
      r_k         <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_op    <= req_op_i;
            r_llr   <= w_llr_in;
            r_u     <= req_u_i;
            r_k     <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_res[int'(r_k)*LLR_W +: LLR_W] <= w_pe_res;
          r_k <= r_k + CW'(1);
          if (r_k == CW'(HALF-1)) begin
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready_i) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign busy_o      = (r_state != ST_IDLE);
  assign res_valid_o = r_res_valid;
  assign res_llr_o   = r_res;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_polar_fg_sched.sv
module tb_polar_fg_sched;
  import polar_pkg::*;

  localparam int N_LLR = 8;
  localparam int W     = 8;
  localparam int HALF  = N_LLR / 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  polar_op_t            req_op = PL_OP_F;
  logic [N_LLR*W-1:0]   req_llr = '0;
  logic [HALF-1:0]      req_u = '0;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [HALF*W-1:0]    res_llr;
  logic                 busy;
  sched_state_t         dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  polar_fg_sched #(.N_LLR(N_LLR), .LLR_W(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_llr_i   (req_llr),
    .req_u_i     (req_u),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_llr_o   (res_llr),
    .busy_o      (busy),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pk8(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic logic [31:0] pk4(input logic [7:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  // independent reference of one PE evaluation, in plain integers
  function automatic logic [7:0] pe_ref(input polar_op_t op, input logic [7:0] ra,
                                        input logic [7:0] rb, input logic u);
    int a, b, ma, mb, m, r;
    a = int'($signed(ra));
    b = int'($signed(rb));
    if (a == -128) a = -127;
    if (b == -128) b = -127;
    if (op == PL_OP_F) begin
      ma = (a < 0) ? -a : a;
      mb = (b < 0) ? -b : b;
      m  = (ma <= mb) ? ma : mb;
      r  = ((a < 0) != (b < 0)) ? -m : m;
    end else begin
      r = u ? (b - a) : (b + a);
      if (r > int'(LLR_MAX)) r = int'(LLR_MAX);
      if (r < int'(LLR_MIN)) r = int'(LLR_MIN);
    end
    return r[7:0];
  endfunction

  function automatic logic [31:0] node_ref(input polar_op_t op, input logic [63:0] llr,
                                           input logic [3:0] u);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < HALF; k++)
      r[k*8 +: 8] = pe_ref(op, llr[k*8 +: 8], llr[(k+HALF)*8 +: 8], u[k]);
    return r;
  endfunction

  // driver tasks (all called at #1 after a rising edge)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input polar_op_t op, input logic [63:0] llr, input logic [3:0] u);
    int n;
    req_op = op; req_llr = llr; req_u = u; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin step(); n++; end
    chk("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 200) begin step(); lat++; end
    chk("res_valid_seen", {63'd0, res_valid}, 64'd1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("res_valid_after_hs", {63'd0, res_valid}, 64'd0);
    chk("req_ready_after_hs", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic run_node(input string tag, input polar_op_t op, input logic [63:0] llr,
                          input logic [3:0] u, input logic [31:0] exp);
    int lat;
    send(op, llr, u);
    wait_result(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(HALF));
    chk({tag, "_res"}, {32'd0, res_llr}, {32'd0, exp});
    handshake();
  endtask

  initial begin
    logic [31:0] held;
    logic [63:0] rl;
    logic [3:0]  ru;
    polar_op_t   rop;
    int          lat;
    int          d;

    // reset state
    step(); step();
    rst = 1'b0;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy}, 64'd0);
    chk("rst_res_llr",   {32'd0, res_llr}, 64'd0);
    chk("rst_state",     {62'd0, dbg_state}, {62'd0, ST_IDLE});

    // F, min-sum with a tie and mixed signs
    run_node("f_basic", PL_OP_F, pk8(8'h05, 8'hFD, 8'h0A, 8'hF9, 8'hFE, 8'h04, 8'hF8, 8'h07),
             4'b0000, pk4(8'hFE, 8'hFD, 8'hF8, 8'hF9));

    // G with saturation both ways, u=0
    run_node("g_u0", PL_OP_G, pk8(8'h64, 8'h9C, 8'h03, 8'h00, 8'h64, 8'h9C, 8'hFB, 8'h00),
             4'b0000, pk4(8'h7F, 8'h81, 8'hFE, 8'h00));

    // same vector, u=0011; res_ready held high through BUSY has no effect
    res_ready = 1'b1;
    send(PL_OP_G, pk8(8'h64, 8'h9C, 8'h03, 8'h00, 8'h64, 8'h9C, 8'hFB, 8'h00), 4'b0011);
    chk("g_u3_busy", {63'd0, busy}, 64'd1);
    chk("g_u3_no_early_valid", {63'd0, res_valid}, 64'd0);
    wait_result(lat);
    chk("g_u3_latency", 64'(lat), 64'(HALF));
    chk("g_u3_res", {32'd0, res_llr}, {32'd0, pk4(8'h00, 8'h00, 8'hFE, 8'h00)});
    handshake();

    // -128 inputs are clamped to -127 before use
    run_node("f_neg_min", PL_OP_F, pk8(8'h80, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00),
             4'b0000, pk4(8'h7F, 8'h00, 8'h00, 8'h00));
    run_node("g_neg_min", PL_OP_G, pk8(8'h80, 8'h80, 8'h80, 8'h01, 8'h7F, 8'h80, 8'h00, 8'h80),
             4'b0000, pk4(8'h00, 8'h81, 8'h81, 8'h82));

    // backpressure: result held 10 cycles while a second request waits
    send(PL_OP_F, pk8(8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFE, 8'hFD, 8'hFC), 4'b0000);
    wait_result(lat);
    held = res_llr;
    chk("bp_res", {32'd0, held}, {32'd0, pk4(8'hFF, 8'hFE, 8'hFD, 8'hFC)});
    req_op = PL_OP_G;
    req_llr = pk8(8'h0A, 8'h14, 8'h1E, 8'h28, 8'h01, 8'h02, 8'h03, 8'h04);
    req_u = 4'b1010;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_stable", {32'd0, res_llr}, {32'd0, held});
      chk("bp_valid_held", {63'd0, res_valid}, 64'd1);
      chk("bp_ready_low", {63'd0, req_ready}, 64'd0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_hs_valid_low", {63'd0, res_valid}, 64'd0);
    chk("bp_idle_after_hs", {63'd0, busy}, 64'd0);
    step();
    req_valid = 1'b0;
    chk("bp_second_accepted", {63'd0, busy}, 64'd1);
    wait_result(lat);
    chk("bp_second_latency", 64'(lat), 64'(HALF));
    chk("bp_second_res", {32'd0, res_llr}, {32'd0, pk4(8'h0B, 8'hEE, 8'h21, 8'hDC)});
    handshake();

    // reset after two slots, with a request presented during reset
    send(PL_OP_G, pk8(8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10), 4'b0000);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
    chk("mid_rst_valid", {63'd0, res_valid}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_res_zero", {32'd0, res_llr}, 64'd0);
    req_valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 1'b0;
    chk("rst_blocks_request", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_result_after_abort", {63'd0, res_valid}, 64'd0);
    end
    run_node("post_rst", PL_OP_F, pk8(8'h00, 8'hFB, 8'h06, 8'hF9, 8'h09, 8'h00, 8'hFA, 8'h03),
             4'b0000, pk4(8'h00, 8'h00, 8'hFA, 8'hFD));

    // random vectors with request and result stalls
    for (int t = 0; t < 40; t++) begin
      rop = polar_op_t'($urandom_range(0, 1));
      rl  = {$urandom(), $urandom()};
      ru  = 4'($urandom_range(0, 15));
      d   = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) step();
      send(rop, rl, ru);
      wait_result(lat);
      chk("rnd_latency", 64'(lat), 64'(HALF));
      chk("rnd_res", {32'd0, res_llr}, {32'd0, node_ref(rop, rl, ru)});
      held = res_llr;
      d = $urandom_range(0, 4);
      for (int i = 0; i < d; i++) begin
        step();
        chk("rnd_stall_stable", {32'd0, res_llr}, {32'd0, held});
      end
      handshake();
      step();
      chk("rnd_no_duplicate", {63'd0, res_valid}, 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
